// File: rtl/custom_subtractor44_19_seq.sv
// Multi-cycle chunked subtractor: Diff = A - zext(B), one CHUNK-bit slice per clock.
// Optional build macro SUB_SATURATE_EN clamps Diff to zero when the final borrow is set.
module custom_subtractor44_19_seq #(
    parameter int unsigned A_WIDTH = 44,
    parameter int unsigned B_WIDTH = 25,
    parameter int unsigned CHUNK   = 11
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [A_WIDTH-1:0] A,
    input  logic [B_WIDTH-1:0] B,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [A_WIDTH-1:0] Diff,
    output logic               Borrow
);

    localparam int unsigned N    = A_WIDTH / CHUNK;
    localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e             state_q, state_d;
    logic [IdxW-1:0]    idx_q, idx_d;
    logic               bin_q, bin_d;
    logic [A_WIDTH-1:0] a_q, a_d;
    logic [A_WIDTH-1:0] bx_q, bx_d;
    logic [A_WIDTH-1:0] diff_q, diff_d;
    logic               borrow_q, borrow_d;

    logic [CHUNK-1:0]   a_sl, b_sl;
    logic [CHUNK:0]     sub;

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        bin_d    = bin_q;
        a_d      = a_q;
        bx_d     = bx_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;
        a_sl     = '0;
        b_sl     = '0;

        for (int k = 0; k < N; k++) begin
            if (idx_q == IdxW'(k)) begin
                a_sl = a_q[k*CHUNK +: CHUNK];
                b_sl = bx_q[k*CHUNK +: CHUNK];
            end
        end
        // Top bit of the (CHUNK+1)-bit difference is the slice borrow-out.
        sub = {1'b0, a_sl} - {1'b0, b_sl} - {{CHUNK{1'b0}}, bin_q};

        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    a_d     = A;
                    bx_d    = A_WIDTH'(B);
                    idx_d   = '0;
                    bin_d   = 1'b0;
                    state_d = StRun;
                end
            end
            StRun: begin
                for (int k = 0; k < N; k++) begin
                    if (idx_q == IdxW'(k)) begin
                        diff_d[k*CHUNK +: CHUNK] = sub[CHUNK-1:0];
                    end
                end
                bin_d = sub[CHUNK];
                idx_d = idx_q + IdxW'(1);
                if (idx_q == IdxW'(N - 1)) begin
                    state_d  = StDone;
                    borrow_d = sub[CHUNK];
`ifdef SUB_SATURATE_EN
                    if (sub[CHUNK]) begin
                        diff_d = '0;
                    end
`endif
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            idx_q    <= '0;
            bin_q    <= 1'b0;
            a_q      <= '0;
            bx_q     <= '0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            bin_q    <= bin_d;
            a_q      <= a_d;
            bx_q     <= bx_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign Diff      = diff_q;
    assign Borrow    = borrow_q;

endmodule

// File: tb/tb_custom_subtractor44_19_seq.sv
// Self-checking bench for custom_subtractor44_19_seq: directed cases plus random operands
// compared against a plain-arithmetic reference model.
module tb_custom_subtractor44_19_seq;

    localparam int unsigned AW = 44;
    localparam int unsigned BW = 25;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [AW-1:0] A;
    logic [BW-1:0] B;
    logic          out_valid;
    logic          out_ready;
    logic [AW-1:0] Diff;
    logic          Borrow;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    custom_subtractor44_19_seq dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Diff      (Diff),
        .Borrow    (Borrow)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic model_borrow(input logic [AW-1:0] a, input logic [BW-1:0] b);
        return a < AW'(b);
    endfunction

    function automatic logic [AW-1:0] model_diff(input logic [AW-1:0] a, input logic [BW-1:0] b);
`ifdef SUB_SATURATE_EN
        if (a < AW'(b)) return '0;
`endif
        return a - AW'(b);
    endfunction

    function automatic logic [AW-1:0] rand_a();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        if (r[0]) r = 64'($urandom_range(0, 32'h0400_0000));
        return r[AW-1:0];
    endfunction

    // Called #1 after a rising edge with the DUT idle; checks the full transaction.
    task automatic run_op(input logic [AW-1:0] a, input logic [BW-1:0] b,
                          input logic [AW-1:0] exp_d, input logic exp_b);
        int lat;
        A         = a;
        B         = b;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        check("in_ready_idle", 64'(in_ready), 64'(1));
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check("latency", 64'(lat), 64'(4));
        check("diff", 64'(Diff), 64'(exp_d));
        check("borrow", 64'(Borrow), 64'(exp_b));
        check("in_ready_done", 64'(in_ready), 64'(0));
        @(posedge clk); #1;
        check("out_valid_fall", 64'(out_valid), 64'(0));
        check("in_ready_back", 64'(in_ready), 64'(1));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [AW-1:0] a, exp_d;
        logic [BW-1:0] b;
        logic          exp_b;
        logic [AW-1:0] qd[$];
        logic          qb[$];
        int            cyc, last, nacc, ndone;
        logic          reroll;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; A = '0; B = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_in_ready", 64'(in_ready), 64'(1));
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_diff", 64'(Diff), 64'(0));
        check("rst_borrow", 64'(Borrow), 64'(0));

        // Directed cases
        run_op(44'h000_0000_0100, 25'h00000FF, 44'h000_0000_0001, 1'b0);
        run_op(44'h000_0080_0000, 25'h0000001, 44'h000_007F_FFFF, 1'b0);
        run_op(44'hFFF_FFFF_FFFF, 25'h1FFFFFF, 44'hFFF_FE00_0000, 1'b0);
`ifdef SUB_SATURATE_EN
        run_op(44'h0, 25'h1, 44'h0, 1'b1);
`else
        run_op(44'h0, 25'h1, 44'hFFF_FFFF_FFFF, 1'b1);
`endif

        // Backpressure in DONE with ignored input activity
        a = 44'h123_4567_89AB; b = 25'h1ABCDEF;
        exp_d = model_diff(a, b); exp_b = model_borrow(a, b);
        A = a; B = b; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("bp_out_valid", 64'(out_valid), 64'(1));
        for (int i = 0; i < 3; i++) begin
            A = rand_a(); B = BW'($urandom()); in_valid = 1'b1;
            @(posedge clk); #1;
            check("bp_hold_valid", 64'(out_valid), 64'(1));
            check("bp_hold_ready", 64'(in_ready), 64'(0));
            check("bp_hold_diff", 64'(Diff), 64'(exp_d));
            check("bp_hold_borrow", 64'(Borrow), 64'(exp_b));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_release_valid", 64'(out_valid), 64'(0));
        check("bp_release_ready", 64'(in_ready), 64'(1));
        a = 44'h000_0ABC_0000; b = 25'h0123456;
        run_op(a, b, model_diff(a, b), model_borrow(a, b));

        // Reset on the second RUN edge
        A = 44'h800_0000_0000; B = 25'h1234567; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_out_valid", 64'(out_valid), 64'(0));
        check("abort_in_ready", 64'(in_ready), 64'(1));
        check("abort_diff", 64'(Diff), 64'(0));
        check("abort_borrow", 64'(Borrow), 64'(0));
        repeat (5) @(posedge clk);
        #1;
        check("abort_no_result", 64'(out_valid), 64'(0));
        a = 44'h000_0000_0005; b = 25'h0000007;
        run_op(a, b, model_diff(a, b), model_borrow(a, b));

        // Random operations
        for (int i = 0; i < 20; i++) begin
            a = rand_a(); b = BW'($urandom());
            run_op(a, b, model_diff(a, b), model_borrow(a, b));
        end

        // Back-to-back with in_valid held high
        in_valid = 1'b1; A = rand_a(); B = BW'($urandom()); out_ready = 1'b1;
        cyc = 0; last = 0; nacc = 0; ndone = 0; reroll = 1'b0;
        while (ndone < 3 && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (out_valid) begin
                check("b2b_diff", 64'(Diff), 64'(qd.pop_front()));
                check("b2b_borrow", 64'(Borrow), 64'(qb.pop_front()));
                ndone++;
            end
            if (in_ready && in_valid) begin
                if (nacc > 0) check("b2b_spacing", 64'(cyc - last), 64'(6));
                last = cyc;
                qd.push_back(model_diff(A, B));
                qb.push_back(model_borrow(A, B));
                nacc++;
                reroll = 1'b1;
            end else if (reroll) begin
                A = rand_a(); B = BW'($urandom());
                reroll = 1'b0;
                if (nacc == 3) in_valid = 1'b0;
            end
        end
        check("b2b_results", 64'(ndone), 64'(3));
        @(posedge clk); #1;
        check("b2b_idle", 64'(in_ready), 64'(1));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/custom_subtractor44_19_seq.md
Name: custom_subtractor44_19_seq

Overview:
Multi-cycle chunked subtractor. Computes A − {19'b0, B} for a 44-bit minuend and a 25-bit zero-extended subtrahend, one CHUNK-bit slice per clock, with a borrow chained between slices. It is the inverse operation of the 44/19 custom adder in the multiplier datapath. Typical uses are exponent/mantissa correction and partial-product removal, where area matters more than latency. Valid/ready handshake on both the input and output sides.

Parameters:
A_WIDTH, 44, minuend and result width; must be a multiple of CHUNK.
B_WIDTH, 25, subtrahend width; zero-extended by A_WIDTH−B_WIDTH (19) bits; B_WIDTH ≤ A_WIDTH.
CHUNK, 11, bits processed per cycle; N = A_WIDTH/CHUNK slice cycles (4 by default).

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
in_valid  input  1  operands valid
in_ready  output  1  block can accept operands
A  input  A_WIDTH  minuend
B  input  B_WIDTH  subtrahend, zero-extended internally
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
Diff  output  A_WIDTH  A − zext(B), modulo 2^A_WIDTH
Borrow  output  1  1 when A < zext(B)

Behaviour:
- Reset: the block is synchronous to clk only. While rst is high at a rising edge, the following apply:
  - state becomes IDLE;
  - slice index becomes 0;
  - internal borrow becomes 0;
  - Diff becomes 0, Borrow 0, out_valid 0, in_ready 1.
- IDLE state:
  - in_ready = 1.
  - On an edge with in_valid = 1, A and zext(B) are latched, the slice index is set to 0, the borrow-in is set to 0, and the state moves to RUN.
  - A and B are don't-care when in_valid = 0.
- RUN state:
  - in_ready = 0.
  - Each edge computes {bout, d} = A[k*CHUNK +: CHUNK] − Bx[k*CHUNK +: CHUNK] − bin for k = index.
  - d is written into Diff slice k, bout is registered as the next bin, and the index increments.
  - On the edge that processes k = N−1, the state moves to DONE and Borrow is set to that slice's bout.
  - In-flight input activity is ignored.
- DONE state:
  - out_valid = 1 and in_ready = 0.
  - Diff and Borrow are held stable while out_ready = 0, for any number of cycles.
  - On an edge with out_ready = 1, the state moves to IDLE and out_valid falls.
  - A new operand is never accepted on the same edge as the handoff; the earliest accept is on the following edge.
- Latency: out_valid rises exactly N rising edges after the accepting edge. With the defaults this is 4, giving 5 cycles from the accept cycle to the result being visible.
- Throughput: one operation per N+2 cycles when out_ready = 1.
- Diff slices not yet written during RUN hold their previous result values. Diff is only architecturally meaningful while out_valid = 1.
- Borrow chains across all slice boundaries. The upper 19 bits of Bx are 0, so slices above B_WIDTH only propagate borrow.
- Reset mid-RUN or mid-DONE: the operation is aborted with no output. The reset values above apply on the next cycle.
- No combinational path from any input to any output except rst through the registered state, because all outputs are registered.

Optional Feature:
SUB_SATURATE_EN:
- When defined: if the final Borrow = 1, Diff is forced to all zeros in DONE (saturating unsigned subtract). Borrow is still reported as 1.
- When undefined: Diff is the wrapped modulo-2^A_WIDTH result.
- Handshake timing is identical in both builds.

Test Plan:
- A=44'h000_0000_0100, B=25'h00000FF, out_ready=1 → out_valid 4 edges after accept, Diff=44'h000_0000_0001, Borrow=0, then back to IDLE with in_ready=1.
- A=44'h000_0080_0000, B=25'h0000001 (borrow crosses the 11- and 22-bit slice boundaries) → Diff=44'h000_007F_FFFF, Borrow=0.
- A=44'hFFF_FFFF_FFFF, B=25'h1FFFFFF → Diff=44'hFFF_FE00_0000, Borrow=0. Then A=0, B=1 → Diff=44'hFFF_FFFF_FFFF, Borrow=1; with SUB_SATURATE_EN, Diff=0, Borrow=1.
- Backpressure: hold out_ready=0 for 3 cycles in DONE → Diff, Borrow and out_valid stable, in_ready=0. Pulse in_valid with new operands meanwhile → ignored. out_ready=1 → IDLE; re-present the operands → accepted one edge later.
- Assert rst for one cycle on the 2nd RUN edge → next cycle out_valid=0, in_ready=1, Diff=0, Borrow=0. A fresh operation afterwards completes correctly with its full 4-edge latency.
- Back-to-back: 3 random operand pairs with in_valid held high and out_ready=1 → each result matches the model A−B mod 2^44, and accepts are spaced 6 cycles apart.
